rv32m_divider: RTL and testbench
================================

// Module: rv32m_divider
// PURPOSE
//   Iterative RV32M divide unit: DIV, DIVU, REM, REMU via restoring division, one quotient bit per cycle.
//   Sits downstream of RegisterFile: consumes read_data1/read_data2 as operands.
//   Returns result and destination register for the write port (write_data / write_address).
//   Control stalls the core while busy=1 and asserts write_enable on done.
// PARAMETERS
//   XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//   clk          in   1     rising-edge clock
//   rst          in   1     asynchronous reset, active-high
//   start        in   1     request a divide; sampled when busy=0
//   flush        in   1     abort in-flight op; no done produced
//   op           in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   operand_a    in   XLEN  dividend (rs1 data)
//   operand_b    in   XLEN  divisor (rs2 data)
//   rd_in        in   5     destination register tag
//   busy         out  1     1 while iterating (state CALC)
//   done         out  1     one-cycle pulse; result/rd_out valid
//   result       out  XLEN  quotient or remainder per op
//   rd_out       out  5     rd_in captured at start
// BEHAVIOUR
//   Reset (async, immediate): state IDLE; busy=0, done=0, result=0, rd_out=0; counter/internal regs cleared.
//   States:
//     IDLE: start=1 & flush=0 -> capture op, rd_in, |a|, |b|, sign flags.
//       divisor==0 or signed overflow -> DONE; otherwise -> CALC with count=XLEN.
//     CALC: one restoring step per edge.
//       rem = {rem[XLEN-2:0], dvd[MSB]}; if rem>=dvs then rem-=dvs, qbit=1.
//       count decrements; count reaches 0 -> DONE.
//     DONE: done=1 for exactly this cycle; registered result/rd_out presented.
//       Next state IDLE, or directly accept a new start (back-to-back allowed).
//   busy = (state==CALC); start while busy=1 is ignored (not queued).
//   Latency: start high in cycle 0.
//     Normal op: done high in cycle XLEN+1 (33).
//     Special case: done high in cycle 1.
//   Signed ops (DIV/REM): divide magnitudes unsigned.
//     Quotient negated iff sign(a)!=sign(b); remainder takes sign of a.
//     All arithmetic is XLEN bits, two's-complement wrap.
//   Divide by zero (b==0):
//     DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> operand_a unchanged.
//   Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF):
//     DIV -> 0x80000000; REM -> 0.
//   result and rd_out hold their value after done until the next completion; not cleared in IDLE.
//   flush=1: next state IDLE from any state; no done. Overrides a simultaneous start and suppresses a DONE pulse
//     scheduled for the next cycle; done already high in the current cycle is unaffected.
//   Reset asserted mid-CALC: immediate return to IDLE/reset values; no done after deassertion.
//   Operands sampled only at the accepting edge; later changes to operand_a/b/op/rd_in have no effect.
// TESTING
//   DIVU a=100 b=7 rd=5, start cycle 0 -> busy cycles 1..32, done cycle 33, result=14, rd_out=5.
//   REMU 100,7 -> 2; DIV a=-7(0xFFFFFFF9) b=2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; REM 7,-2 -> 1.
//   DIVU 5/0 -> 0xFFFFFFFF, done cycle 1, busy never high; REMU 5/0 -> 5.
//     DIV 0x80000000/0xFFFFFFFF -> 0x80000000 (cycle 1); REM same operands -> 0.
//   Start DIVU 100/7, pulse start with REMU 9/4 at cycle 10 -> ignored, result=14 at cycle 33.
//     Back-to-back start in the done cycle -> second op accepted.
//   Flush at cycle 15 -> busy=0 cycle 16, no done ever.
//     Async rst mid-CALC -> outputs 0 immediately; next start runs normally.

Source files
------------

// File: rtl/rv32m_divider_if.sv
// Request/response bundle between the issue stage and the RV32M divide unit.
// The master issues operands and a destination tag; the slave reports busy/done/result.
interface rv32m_divider_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [1:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, flush, op, operand_a, operand_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, flush, op, operand_a, operand_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/rv32m_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: restoring division on operand magnitudes,
// one quotient bit per cycle, with single-cycle handling of divide-by-zero and signed overflow.
module rv32m_divider #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    rv32m_divider_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dvs;
    logic [CW-1:0]   r_count;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [4:0]      r_rd_tag;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd_out;

    logic            w_busy;
    logic            w_done;
    logic            w_accept;
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN:0]   w_rem_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_step;
    logic [XLEN-1:0] w_quo_step;
    logic [XLEN-1:0] w_final;
    logic            w_last;

    // A new request can be taken in IDLE and also in DONE, which allows back-to-back issue.
    assign w_accept = (r_state != S_CALC) && bus.start && !bus.flush;

    assign w_signed   = !bus.op[0];
    assign w_a_neg    = w_signed && bus.operand_a[XLEN-1];
    assign w_b_neg    = w_signed && bus.operand_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~bus.operand_a + ONE) : bus.operand_a;
    assign w_b_mag    = w_b_neg ? (~bus.operand_b + ONE) : bus.operand_b;
    assign w_div_zero = (bus.operand_b == '0);
    assign w_ovf      = w_signed && (bus.operand_a == MIN_NEG) && (bus.operand_b == '1);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = bus.op[1] ? bus.operand_a : '1;
        end else begin
            w_special_res = bus.op[1] ? '0 : MIN_NEG;
        end
    end

    // Partial remainder is kept one bit wider during the compare so large unsigned divisors work.
    assign w_rem_shift = {r_rem, r_dvd[XLEN-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_dvs};
    assign w_ge        = !w_diff[XLEN];
    assign w_rem_step  = w_ge ? w_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];
    assign w_quo_step  = {r_dvd[XLEN-2:0], w_ge};
    assign w_last      = (r_state == S_CALC) && (r_count == CNT_ONE);

    always_comb begin
        w_final = '0;
        if (r_is_rem) begin
            w_final = r_neg_r ? (~w_rem_step + ONE) : w_rem_step;
        end else begin
            w_final = r_neg_q ? (~w_quo_step + ONE) : w_quo_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_done = (r_state == S_DONE);
                if (w_accept) begin
                    w_state_next = w_special ? S_DONE : S_CALC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (bus.flush) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Result and rd_out only change on a completion, so they stay valid after done drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_count  <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rd_tag <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else if (w_accept) begin
            r_rem    <= '0;
            r_dvd    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_count  <= CNT_INIT;
            r_is_rem <= bus.op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_rd_tag <= bus.rd_in;
            if (w_special) begin
                r_result <= w_special_res;
                r_rd_out <= bus.rd_in;
            end
        end else if ((r_state == S_CALC) && !bus.flush) begin
            r_rem   <= w_rem_step;
            r_dvd   <= w_quo_step;
            r_count <= r_count - CNT_ONE;
            if (w_last) begin
                r_result <= w_final;
                r_rd_out <= r_rd_tag;
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
    assign bus.rd_out = r_rd_out;
endmodule

// File: tb/tb_rv32m_divider.sv
// Directed bench for rv32m_divider: latency, signed/unsigned arithmetic, special cases,
// ignored and back-to-back starts, flush and asynchronous reset.
module tb_rv32m_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    rv32m_divider_if #(.XLEN(32)) dif ();

    rv32m_divider #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        dif.op        = op;
        dif.operand_a = a;
        dif.operand_b = b;
        dif.rd_in     = rd;
        dif.start     = 1'b1;
    endtask

    // Ticks until done, scrambling the operand inputs once the request has been sampled.
    task automatic wait_done(input int limit, output int cyc, output int busy_n);
        cyc    = 0;
        busy_n = 0;
        do begin
            tick();
            cyc++;
            if (cyc == 1) begin
                dif.start     = 1'b0;
                dif.op        = ~dif.op;
                dif.operand_a = ~dif.operand_a;
                dif.operand_b = 32'd3;
                dif.rd_in     = ~dif.rd_in;
            end
            if (dif.busy) busy_n++;
        end while (!dif.done && cyc < limit);
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_chk++; if (dif.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", dif.busy); else n_pass++;
        n_chk++; if (dif.done !== 1'b0) $display("FAIL reset_done got %b want 0", dif.done); else n_pass++;
        n_chk++; if (dif.result !== 32'h0) $display("FAIL reset_result got %h want 0", dif.result); else n_pass++;
        n_chk++; if (dif.rd_out !== 5'd0) $display("FAIL reset_rd got %0d want 0", dif.rd_out); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        $display("reset released: busy=%b done=%b result=%h", dif.busy, dif.done, dif.result);
    endtask

    task automatic test_divu_latency();
        int cyc, bn;
        issue(2'b01, 32'd100, 32'd7, 5'd5);
        wait_done(60, cyc, bn);
        $display("DIVU 100/7: done cycle %0d busy cycles %0d result %0d rd %0d", cyc, bn, dif.result, dif.rd_out);
        n_chk++; if (cyc !== 33) $display("FAIL divu_done_cycle got %0d want 33", cyc); else n_pass++;
        n_chk++; if (bn !== 32) $display("FAIL divu_busy_cycles got %0d want 32", bn); else n_pass++;
        n_chk++; if (dif.result !== 32'd14) $display("FAIL divu_result got %h want %h", dif.result, 32'd14); else n_pass++;
        n_chk++; if (dif.rd_out !== 5'd5) $display("FAIL divu_rd got %0d want 5", dif.rd_out); else n_pass++;
        tick();
        n_chk++; if (dif.done !== 1'b0) $display("FAIL done_pulse_width got %b want 0", dif.done); else n_pass++;
        n_chk++; if (dif.result !== 32'd14) $display("FAIL result_hold got %h want %h", dif.result, 32'd14); else n_pass++;
    endtask

    task automatic test_arith();
        vec_t v[9];
        int cyc, bn;
        v[0] = '{2'b11, 32'd100,        32'd7,        32'd2};
        v[1] = '{2'b00, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD};
        v[2] = '{2'b10, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF};
        v[3] = '{2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1};
        v[4] = '{2'b00, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA};
        v[5] = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001, 32'd1};
        v[6] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0001, 32'h7FFF_FFFE};
        v[7] = '{2'b00, 32'h8000_0000,  32'd2,        32'hC000_0000};
        v[8] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        for (int i = 0; i < 9; i++) begin
            issue(v[i].op, v[i].a, v[i].b, 5'(i + 10));
            wait_done(60, cyc, bn);
            $display("op=%b a=%h b=%h -> %h (want %h) cycle %0d", v[i].op, v[i].a, v[i].b, dif.result, v[i].exp, cyc);
            n_chk++; if (dif.result !== v[i].exp) $display("FAIL arith_result[%0d] got %h want %h", i, dif.result, v[i].exp); else n_pass++;
            n_chk++; if (cyc !== 33) $display("FAIL arith_cycle[%0d] got %0d want 33", i, cyc); else n_pass++;
            n_chk++; if (dif.rd_out !== 5'(i + 10)) $display("FAIL arith_rd[%0d] got %0d want %0d", i, dif.rd_out, i + 10); else n_pass++;
        end
    endtask

    task automatic test_special();
        vec_t v[6];
        int cyc, bn;
        v[0] = '{2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF};
        v[1] = '{2'b11, 32'd5,         32'd0,         32'd5};
        v[2] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        v[4] = '{2'b00, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
        v[5] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
        for (int i = 0; i < 6; i++) begin
            issue(v[i].op, v[i].a, v[i].b, 5'(i + 20));
            wait_done(60, cyc, bn);
            $display("special op=%b a=%h b=%h -> %h (want %h) cycle %0d", v[i].op, v[i].a, v[i].b, dif.result, v[i].exp, cyc);
            n_chk++; if (dif.result !== v[i].exp) $display("FAIL special_result[%0d] got %h want %h", i, dif.result, v[i].exp); else n_pass++;
            n_chk++; if (cyc !== 1) $display("FAIL special_cycle[%0d] got %0d want 1", i, cyc); else n_pass++;
            n_chk++; if (bn !== 0) $display("FAIL special_busy[%0d] got %0d want 0", i, bn); else n_pass++;
            n_chk++; if (dif.rd_out !== 5'(i + 20)) $display("FAIL special_rd[%0d] got %0d want %0d", i, dif.rd_out, i + 20); else n_pass++;
            tick();
        end
    endtask

    task automatic test_ignored_start();
        int cyc = 0;
        issue(2'b01, 32'd100, 32'd7, 5'd5);
        do begin
            tick();
            cyc++;
            dif.start = (cyc == 10);
            if (cyc == 10) begin
                dif.op        = 2'b11;
                dif.operand_a = 32'd9;
                dif.operand_b = 32'd4;
                dif.rd_in     = 5'd9;
            end
        end while (!dif.done && cyc < 60);
        dif.start = 1'b0;
        $display("ignored start: done cycle %0d result %0d rd %0d", cyc, dif.result, dif.rd_out);
        n_chk++; if (cyc !== 33) $display("FAIL ignored_cycle got %0d want 33", cyc); else n_pass++;
        n_chk++; if (dif.result !== 32'd14) $display("FAIL ignored_result got %h want %h", dif.result, 32'd14); else n_pass++;
        n_chk++; if (dif.rd_out !== 5'd5) $display("FAIL ignored_rd got %0d want 5", dif.rd_out); else n_pass++;
        tick();
        tick();
        n_chk++; if (dif.busy !== 1'b0) $display("FAIL ignored_not_queued got busy %b want 0", dif.busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc, bn;
        issue(2'b01, 32'd100, 32'd7, 5'd5);
        wait_done(60, cyc, bn);
        n_chk++; if (dif.done !== 1'b1) $display("FAIL b2b_first_done got %b want 1", dif.done); else n_pass++;
        issue(2'b11, 32'd100, 32'd7, 5'd3);
        wait_done(60, cyc, bn);
        $display("back-to-back REMU 100/7: done cycle %0d result %0d rd %0d", cyc, dif.result, dif.rd_out);
        n_chk++; if (cyc !== 33) $display("FAIL b2b_cycle got %0d want 33", cyc); else n_pass++;
        n_chk++; if (dif.result !== 32'd2) $display("FAIL b2b_result got %h want %h", dif.result, 32'd2); else n_pass++;
        n_chk++; if (dif.rd_out !== 5'd3) $display("FAIL b2b_rd got %0d want 3", dif.rd_out); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        int cyc;
        int n_done;
        for (int k = 0; k < 2; k++) begin
            int fc = (k == 0) ? 15 : 32;
            cyc = 0;
            issue(2'b01, 32'd1000, 32'd10, 5'd6);
            while (cyc < fc) begin
                tick();
                cyc++;
                dif.start = 1'b0;
            end
            dif.flush = 1'b1;
            tick();
            dif.flush = 1'b0;
            $display("flush at cycle %0d: busy=%b done=%b", fc, dif.busy, dif.done);
            n_chk++; if (dif.busy !== 1'b0) $display("FAIL flush_busy[%0d] got %b want 0", k, dif.busy); else n_pass++;
            n_done = 0;
            for (int j = 0; j < 40; j++) begin
                if (dif.done) n_done++;
                tick();
            end
            n_chk++; if (n_done !== 0) $display("FAIL flush_no_done[%0d] got %0d pulses want 0", k, n_done); else n_pass++;
            n_chk++; if (dif.result !== 32'd2) $display("FAIL flush_result_kept[%0d] got %h want %h", k, dif.result, 32'd2); else n_pass++;
        end
        issue(2'b01, 32'd5, 32'd0, 5'd7);
        dif.flush = 1'b1;
        tick();
        dif.start = 1'b0;
        dif.flush = 1'b0;
        $display("flush with start: done=%b result=%h", dif.done, dif.result);
        n_chk++; if (dif.done !== 1'b0) $display("FAIL flush_over_start got done %b want 0", dif.done); else n_pass++;
        n_chk++; if (dif.rd_out !== 5'd3) $display("FAIL flush_over_start_rd got %0d want 3", dif.rd_out); else n_pass++;
    endtask

    task automatic test_async_reset();
        int cyc, bn;
        int n_done = 0;
        issue(2'b01, 32'd1000, 32'd10, 5'd7);
        for (int j = 0; j < 10; j++) begin
            tick();
            dif.start = 1'b0;
        end
        #3 rst = 1'b1;
        #1;
        $display("async reset mid-CALC: busy=%b done=%b result=%h rd=%0d", dif.busy, dif.done, dif.result, dif.rd_out);
        n_chk++; if (dif.busy !== 1'b0) $display("FAIL arst_busy got %b want 0", dif.busy); else n_pass++;
        n_chk++; if (dif.result !== 32'h0) $display("FAIL arst_result got %h want 0", dif.result); else n_pass++;
        n_chk++; if (dif.rd_out !== 5'd0) $display("FAIL arst_rd got %0d want 0", dif.rd_out); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (dif.done) n_done++;
        end
        n_chk++; if (n_done !== 0) $display("FAIL arst_no_done got %0d pulses want 0", n_done); else n_pass++;
        issue(2'b01, 32'd1000, 32'd10, 5'd7);
        wait_done(60, cyc, bn);
        $display("after reset DIVU 1000/10: cycle %0d result %0d rd %0d", cyc, dif.result, dif.rd_out);
        n_chk++; if (cyc !== 33) $display("FAIL arst_rerun_cycle got %0d want 33", cyc); else n_pass++;
        n_chk++; if (dif.result !== 32'd100) $display("FAIL arst_rerun_result got %h want %h", dif.result, 32'd100); else n_pass++;
        n_chk++; if (dif.rd_out !== 5'd7) $display("FAIL arst_rerun_rd got %0d want 7", dif.rd_out); else n_pass++;
    endtask

    initial begin
        dif.start     = 1'b0;
        dif.flush     = 1'b0;
        dif.op        = 2'b00;
        dif.operand_a = '0;
        dif.operand_b = '0;
        dif.rd_in     = '0;
        test_reset();
        test_divu_latency();
        test_arith();
        test_special();
        test_ignored_start();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
